// File: rtl/fb_display_scanout.sv
// Framebuffer commit-stream scanout: unpacks RGBA4444 beats into an RGB565 AXI4-Stream-Video pixel stream.
// Defining FB_SCANOUT_ERROR_COUNT_EN adds a saturating framing-error counter with a clear input.
module fb_display_scanout #(
    parameter int STREAM_WIDTH   = 16,
    parameter int PIXEL_WIDTH    = 16,
    parameter int DISPLAY_WIDTH  = 128,
    parameter int DISPLAY_HEIGHT = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [15:0]             m_axis_tdata,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    frame_done,
    output logic                    frame_error
`ifdef FB_SCANOUT_ERROR_COUNT_EN
    ,
    output logic [15:0]             error_count,
    input  logic                    error_count_clear
`endif
);
    localparam int PIXEL_PER_BEAT = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int IDX_W = (PIXEL_PER_BEAT > 1) ? $clog2(PIXEL_PER_BEAT) : 1;
    localparam int X_W   = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
    localparam int Y_W   = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_PER_BEAT - 1);
    localparam logic [X_W-1:0]   LAST_X   = X_W'(DISPLAY_WIDTH - 1);
    localparam logic [Y_W-1:0]   LAST_Y   = Y_W'(DISPLAY_HEIGHT - 1);

    logic                    holdValid;
    logic                    holdLast;
    logic [STREAM_WIDTH-1:0] holdData;
    logic [IDX_W-1:0]        pixIdx;
    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic                    outFrameEnd;
    logic                    outLoad;
    logic                    beatDone;
    logic                    accept;
    logic                    frameEnd;
    logic [PIXEL_WIDTH-1:0]  pix;
    logic [15:0]             rgb;
    logic                    unusedPix;

    assign outLoad       = holdValid && (!m_axis_tvalid || m_axis_tready);
    assign beatDone      = outLoad && (pixIdx == LAST_IDX);
    assign s_axis_tready = !reset && (!holdValid || beatDone);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign frameEnd      = (x == LAST_X) && (y == LAST_Y);

    always_comb begin
        pix = '0;
        for (int k = 0; k < PIXEL_PER_BEAT; k++)
            if (pixIdx == IDX_W'(k)) pix = holdData[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    // Widen by replicating MSBs so full-scale 4-bit channels map to full-scale 5/6-bit ones.
    assign rgb       = {pix[15:12], pix[15], pix[11:8], pix[11:10], pix[7:4], pix[7]};
    assign unusedPix = ^pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            holdValid     <= 1'b0;
            holdLast      <= 1'b0;
            holdData      <= '0;
            pixIdx        <= '0;
            x             <= '0;
            y             <= '0;
            outFrameEnd   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (accept) begin
                holdValid <= 1'b1;
                holdData  <= s_axis_tdata;
                holdLast  <= s_axis_tlast;
            end else if (beatDone) begin
                holdValid <= 1'b0;
            end
            if (outLoad) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= rgb;
                m_axis_tuser  <= (x == '0) && (y == '0);
                m_axis_tlast  <= (x == LAST_X);
                outFrameEnd   <= frameEnd;
                pixIdx        <= (pixIdx == LAST_IDX) ? '0 : pixIdx + 1'b1;
                // Early tlast: resync so the next pixel starts a fresh frame.
                if (beatDone && holdLast && !frameEnd) begin
                    x           <= '0;
                    y           <= '0;
                    frame_error <= 1'b1;
                end else begin
                    if (beatDone && !holdLast && frameEnd) frame_error <= 1'b1;
                    if (x == LAST_X) begin
                        x <= '0;
                        y <= (y == LAST_Y) ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Pulses in the cycle the frame's final pixel is taken downstream.
    assign frame_done = m_axis_tvalid && m_axis_tready && outFrameEnd;

`ifdef FB_SCANOUT_ERROR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || error_count_clear)
            error_count <= '0;
        else if (frame_error && error_count != 16'hFFFF)
            error_count <= error_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fb_display_scanout.sv
// Scoreboard bench for fb_display_scanout: a linear-position frame model predicts every output pixel.
module tb_fb_display_scanout;
    localparam int SW   = 32;
    localparam int PW   = 16;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int PPB  = SW / PW;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [SW-1:0] s_axis_tdata = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          frame_error;
`ifdef FB_SCANOUT_ERROR_COUNT_EN
    logic [15:0]   error_count;
    logic          error_count_clear = 1'b0;
`endif

    fb_display_scanout #(
        .STREAM_WIDTH(SW), .PIXEL_WIDTH(PW), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .frame_error(frame_error)
`ifdef FB_SCANOUT_ERROR_COUNT_EN
        , .error_count(error_count), .error_count_clear(error_count_clear)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] rgb; logic sof, eol, done, err; } exp_t;
    exp_t q[$];

    int pos = 0;
    int checks = 0, fails = 0;
    int cyc = 0;
    int readyMode = 0, patPh = 0;
    int doneSeen = 0, errSeen = 0, expDone = 0, expErr = 0;
    int tpArm = 0, tpFirst = -1, tpLast = -1, acceptCyc = 0;
    logic        pendErr = 1'b0, stallPrev = 1'b0;
    logic [17:0] stallVal = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bound expired or unplanned event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] to565(input logic [15:0] p);
        int r, g, b;
        r = (p >> 12) & 15;
        g = (p >> 8) & 15;
        b = (p >> 4) & 15;
        return 16'((r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8));
    endfunction

    // Reference: pos is the linear pixel index within the frame being scanned out.
    task automatic model_beat(input logic [SW-1:0] data, input logic last);
        exp_t e;
        logic [15:0] p;
        for (int k = 0; k < PPB; k++) begin
            p     = data[k*PW +: PW];
            e.rgb = to565(p);
            e.sof = (pos == 0);
            e.eol = (pos % W) == W - 1;
            e.done = (pos == NPIX - 1);
            e.err = (k == PPB - 1) && (last != (pos == NPIX - 1));
            if (e.done) expDone++;
            if (e.err) expErr++;
            q.push_back(e);
            if (k == PPB - 1 && last && pos != NPIX - 1) pos = 0;
            else pos = (pos + 1) % NPIX;
        end
    endtask

    task automatic send_beat(input logic [SW-1:0] data, input logic last);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        while (1) begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin fail_now("s_tready_wait"); break; end
        end
        if (s_axis_tready) begin
            model_beat(data, last);
            acceptCyc = cyc;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 || m_axis_tvalid) begin
            @(posedge clk); #2;
            n++;
            if (n > 1000) begin fail_now("drain"); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic lastOnFinal);
        for (int b = 0; b < NPIX / PPB; b++)
            send_beat($urandom, lastOnFinal && (b == NPIX / PPB - 1));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: m_axis_tready = 1'b1;
            1: begin m_axis_tready = (patPh == 0 || patPh == 3); patPh = (patPh + 1) % 4; end
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            stallPrev = 1'b0;
            pendErr   = 1'b0;
        end else begin
            if (stallPrev) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_fields", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, stallVal);
            end
            if (frame_error) begin errSeen++; pendErr = 1'b1; end
            if (frame_done) doneSeen++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) fail_now("unexpected_pixel");
                else begin
                    e = q.pop_front();
                    chk("tdata", m_axis_tdata, e.rgb);
                    chk("tuser", m_axis_tuser, e.sof);
                    chk("tlast", m_axis_tlast, e.eol);
                    chk("frame_done", frame_done, e.done);
                    chk("frame_error", pendErr, e.err);
                    pendErr = 1'b0;
                    if (tpArm != 0) begin
                        if (tpFirst < 0) tpFirst = cyc;
                        tpLast = cyc;
                    end
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            stallPrev = m_axis_tvalid && !m_axis_tready;
            stallVal  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0, acc0, n;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
        chk("rst_pulses", {frame_done, frame_error}, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_s_tready", s_axis_tready, 1);
        @(posedge clk); #1;

        // Directed frame with fixed pattern
        readyMode = 0;
        for (int b = 0; b < 4; b++) send_beat(32'hF00F_0F0F, b == 3);
        drain();
        chk("plan_done_count", doneSeen, 1);
        chk("plan_error_count", errSeen, 0);

        // Backpressure 1,0,0,1
        readyMode = 1;
        send_frame(1'b1);
        send_frame(1'b1);
        drain();

        // Continuous input, ready held high: one pixel per clock
        readyMode = 0;
        @(posedge clk); #1;
        tpArm = 1; tpFirst = -1;
        send_beat($urandom, 1'b0);
        acc0 = acceptCyc;
        for (int b = 1; b < 8; b++) send_beat($urandom, b == 3 || b == 7);
        drain();
        tpArm = 0;
        chk("throughput_span", tpLast - tpFirst, 8 * PPB - 1);
        chk("first_pixel_latency", tpFirst - acc0, 2);

        // Early tlast on beat 2 of 4
        e0 = errSeen; d0 = doneSeen;
        for (int b = 0; b < 4; b++) send_beat($urandom, b == 1);
        drain();
        chk("early_err_pulses", errSeen - e0, 1);
        chk("early_no_done", doneSeen - d0, 0);
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b1);
        drain();

        // Missing tlast on beat 4
        e0 = errSeen; d0 = doneSeen;
        send_frame(1'b0);
        drain();
        chk("missing_err_pulses", errSeen - e0, 1);
        chk("missing_done_pulses", doneSeen - d0, 1);
        send_frame(1'b1);
        drain();

        // Reset mid-frame with a stalled output pixel
        readyMode = 3;
        send_beat($urandom, 1'b0);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin @(negedge clk); n++; end
        if (!m_axis_tvalid) fail_now("stall_fill");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_m_tvalid", m_axis_tvalid, 0);
        chk("midrst_fields", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 0);
        chk("midrst_pulses", {frame_done, frame_error}, 0);
        chk("midrst_s_tready", s_axis_tready, 0);
        foreach (q[i]) begin
            if (q[i].done) expDone--;
            if (q[i].err) expErr--;
        end
        q.delete();
        pos = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        readyMode = 0;
        send_frame(1'b1);
        drain();

        // Randomised traffic with occasional framing faults
        readyMode = 2;
        for (int b = 0; b < 120; b++)
            send_beat($urandom, (pos == NPIX - PPB) ^ ($urandom_range(0, 11) == 0));
        drain();
        readyMode = 0;
        chk("total_done", doneSeen, expDone);
        chk("total_err", errSeen, expErr);

`ifdef FB_SCANOUT_ERROR_COUNT_EN
        error_count_clear = 1'b1;
        @(posedge clk); #1;
        error_count_clear = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(1'b0);
        drain();
        @(negedge clk);
        chk("error_count_3", error_count, 3);
        @(posedge clk); #1;
        error_count_clear = 1'b1;
        @(posedge clk); #1;
        error_count_clear = 1'b0;
        @(negedge clk);
        chk("error_count_clear", error_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
